fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The block SHALL have parameter REG_WIDTH, default 9, the width of every instruction address.
REQ-002 The block SHALL have parameter START_ADDR, default 9'd0, the first fetch address after reset.
REQ-003 The block SHALL have parameter INSTRUCTION_OFFSET, default 4, the sequential address increment in bytes.
REQ-004 Port: clk, input, 1, the single clock; all logic is on the posedge.
REQ-005 Port: reset, input, 1, synchronous active-high reset.
REQ-006 Port: branch_taken, input, 1, redirect strobe.
REQ-007 Port: branch_target, input, REG_WIDTH, redirect address.
REQ-008 Port: imem_req, output, 1, fetch request valid.
REQ-009 Port: imem_addr, output, REG_WIDTH, fetch address.
REQ-010 Port: imem_gnt, input, 1, memory accepts the request in the current cycle.
REQ-011 Port: imem_rvalid, input, 1, response valid; it arrives 1 or more cycles after the grant.
REQ-012 Port: imem_rdata, input, 32, response instruction word.
REQ-013 Port: instr_valid, output, 1, buffered instruction available to decode.
REQ-014 Port: instr_data, output, 32, buffered instruction word.
REQ-015 Port: instr_addr, output, REG_WIDTH, address of the buffered instruction.
REQ-016 Port: instr_ready, input, 1, decode accepts the buffered instruction.

Function
REQ-017 The block SHALL implement the FSM states IDLE, REQ, WAIT, HOLD and DRAIN, with at most one memory request outstanding at any time.
REQ-018 IDLE SHALL last exactly 1 cycle and then go to REQ.
REQ-019 In REQ, imem_req SHALL be 1 and imem_addr SHALL equal fetch_pc; on imem_gnt the FSM SHALL go to WAIT.
REQ-020 In WAIT, on imem_rvalid the block SHALL register imem_rdata into instr_data and fetch_pc into instr_addr, then go to HOLD.
REQ-021 In HOLD, instr_valid SHALL be 1; on instr_ready, fetch_pc SHALL advance by INSTRUCTION_OFFSET and the FSM SHALL go to REQ.
REQ-022 Address arithmetic SHALL be modulo 2^REG_WIDTH (508 + 4 = 0 at width 9), and the low 2 bits of branch_target SHALL be forced to 0.
REQ-023 On branch_taken in any non-IDLE state, fetch_pc SHALL load branch_target, and branch_taken SHALL override every other transition in that cycle.
REQ-024 Branch in REQ without imem_gnt: stay in REQ, with imem_addr showing the new target in the next cycle.
REQ-025 Branch in REQ with imem_gnt, or branch in WAIT without imem_rvalid: go to DRAIN.
REQ-026 DRAIN SHALL hold imem_req at 0 and discard the stale response; on imem_rvalid it SHALL go to REQ.
REQ-027 A further branch while in DRAIN SHALL update fetch_pc and stay in DRAIN.
REQ-028 Branch in WAIT with imem_rvalid in the same cycle: discard the response and go to REQ.
REQ-029 Branch in HOLD, including the same cycle as instr_ready: go to REQ with instr_valid = 0 the next cycle; fetch_pc SHALL equal the target, not target + 4.
REQ-030 A branch in IDLE SHALL load fetch_pc only, and the FSM SHALL go to REQ.
REQ-031 instr_valid SHALL be 1 only in HOLD, and instr_data and instr_addr SHALL be stable while instr_valid is 1.
REQ-032 The minimum cycle time for sequential instructions SHALL be 3 cycles per instruction (REQ, WAIT, HOLD) with a 1-cycle grant and 1-cycle response.

Reset
REQ-033 On reset, the FSM SHALL go to IDLE and fetch_pc SHALL be START_ADDR.
REQ-034 On reset, imem_req SHALL be 0, imem_addr SHALL be START_ADDR, instr_valid SHALL be 0, instr_data SHALL be 0 and instr_addr SHALL be START_ADDR.
REQ-035 Reset asserted mid-request SHALL abandon the outstanding transaction, and the memory SHALL be reset in the same cycle.
REQ-036 reset SHALL take priority over branch_taken.

Structure
REQ-037 Package fetch_pkg SHALL hold the FSM state enum, INSTR_WIDTH = 32 and the default INSTRUCTION_OFFSET.
REQ-038 fetch_pc, the FSM and the instruction buffer SHALL be inline, with no sub-module, because the existing program counter cannot hold its value and so is not reused.

Verification
REQ-039 Sequential fetch: release reset, memory with 1-cycle grant and 1-cycle response, instr_ready = 1 -> imem_addr sequence 0, 4, 8, with instr_valid asserted first 4 cycles after reset.
REQ-040 Wrap: branch to 508 -> next sequential imem_addr = 0.
REQ-041 Branch in WAIT with 3-cycle response latency, target 100 -> stale word never sets instr_valid; next imem_addr = 100 in the cycle after rvalid.
REQ-042 Branch in HOLD with instr_ready = 1 in the same cycle, target 64 -> instr_valid = 0 next cycle, imem_addr = 64 (not 68).
REQ-043 Backpressure: instr_ready = 0 for 5 cycles in HOLD -> instr_data and instr_addr stable and imem_req = 0 throughout.
REQ-044 Reset in WAIT -> next cycle imem_req = 0, instr_valid = 0, then a fetch from START_ADDR.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

  localparam int INSTR_WIDTH                = 32;
  localparam int DEFAULT_INSTRUCTION_OFFSET = 4;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    DRAIN
  } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl.sv
// Single-outstanding instruction fetch controller: PC, request FSM and a
// one-entry instruction buffer toward decode, with branch redirect/squash.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                   REG_WIDTH          = 9,
  parameter logic [REG_WIDTH-1:0] START_ADDR         = '0,
  parameter int                   INSTRUCTION_OFFSET = DEFAULT_INSTRUCTION_OFFSET
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   branch_taken,
  input  logic [REG_WIDTH-1:0]   branch_target,
  output logic                   imem_req,
  output logic [REG_WIDTH-1:0]   imem_addr,
  input  logic                   imem_gnt,
  input  logic                   imem_rvalid,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   instr_valid,
  output logic [INSTR_WIDTH-1:0] instr_data,
  output logic [REG_WIDTH-1:0]   instr_addr,
  input  logic                   instr_ready
);

  fetch_state_e           r_state;
  fetch_state_e           w_state_next;
  logic [REG_WIDTH-1:0]   r_fetch_pc;
  logic [REG_WIDTH-1:0]   w_fetch_pc_next;
  logic [INSTR_WIDTH-1:0] r_instr_data;
  logic [REG_WIDTH-1:0]   r_instr_addr;
  logic                   w_capture;
  logic [REG_WIDTH-1:0]   w_target_aligned;
  logic [REG_WIDTH-1:0]   w_pc_seq;

  // Targets are word aligned; sequential increment wraps at 2^REG_WIDTH.
  assign w_target_aligned = branch_target & ~REG_WIDTH'(3);
  assign w_pc_seq         = r_fetch_pc + REG_WIDTH'(INSTRUCTION_OFFSET);

  always_comb begin
    w_state_next    = r_state;
    w_fetch_pc_next = r_fetch_pc;
    w_capture       = 1'b0;
    case (r_state)
      IDLE: begin
        w_state_next = REQ;
        if (branch_taken) w_fetch_pc_next = w_target_aligned;
      end
      REQ: begin
        if (branch_taken) begin
          w_fetch_pc_next = w_target_aligned;
          w_state_next    = imem_gnt ? DRAIN : REQ;
        end else if (imem_gnt) begin
          w_state_next = WAIT;
        end
      end
      WAIT: begin
        if (branch_taken) begin
          w_fetch_pc_next = w_target_aligned;
          w_state_next    = imem_rvalid ? REQ : DRAIN;
        end else if (imem_rvalid) begin
          w_capture    = 1'b1;
          w_state_next = HOLD;
        end
      end
      HOLD: begin
        if (branch_taken) begin
          w_fetch_pc_next = w_target_aligned;
          w_state_next    = REQ;
        end else if (instr_ready) begin
          w_fetch_pc_next = w_pc_seq;
          w_state_next    = REQ;
        end
      end
      DRAIN: begin
        if (branch_taken) w_fetch_pc_next = w_target_aligned;
        // The stale response retires the outstanding request even if a new
        // branch lands in the same cycle; waiting longer would never end.
        if (imem_rvalid) w_state_next = REQ;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_fetch_pc   <= START_ADDR;
      r_instr_data <= '0;
      r_instr_addr <= START_ADDR;
    end else begin
      r_state    <= w_state_next;
      r_fetch_pc <= w_fetch_pc_next;
      if (w_capture) begin
        r_instr_data <= imem_rdata;
        r_instr_addr <= r_fetch_pc;
      end
    end
  end

  assign imem_req    = (r_state == REQ);
  assign imem_addr   = r_fetch_pc;
  assign instr_valid = (r_state == HOLD);
  assign instr_data  = r_instr_data;
  assign instr_addr  = r_instr_addr;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: behavioural memory with programmable
// response latency, scoreboard of accepted instructions, branch vector table.
module tb_fetch_ctrl;

  typedef struct {
    logic [8:0]  addr;
    logic [31:0] data;
  } sb_t;

  typedef struct {
    logic [8:0] target;
    logic [8:0] exp_pc;
    logic [8:0] exp_next;
  } br_vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        branch_taken;
  logic [8:0]  branch_target;
  logic        imem_req;
  logic [8:0]  imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [8:0]  instr_addr;
  logic        instr_ready;

  bit          gnt_en;
  int          rsp_lat;
  logic        mem_busy;
  int          mem_cnt;
  logic [8:0]  mem_paddr;

  int          n_checks = 0;
  int          n_fail   = 0;
  sb_t         sb_q[$];
  br_vec_t     br_tab[5];

  fetch_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr_data    (instr_data),
    .instr_addr    (instr_addr),
    .instr_ready   (instr_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [8:0] a);
    return 32'hC0DE_0000 | {23'd0, a} | ({23'd0, a} << 16);
  endfunction

  // Memory: combinational grant, response rsp_lat cycles after the grant.
  assign imem_gnt = imem_req && gnt_en;

  always @(posedge clk) begin
    if (reset) begin
      mem_busy    <= 1'b0;
      mem_cnt     <= 0;
      mem_paddr   <= '0;
      imem_rvalid <= 1'b0;
      imem_rdata  <= '0;
    end else begin
      imem_rvalid <= 1'b0;
      if (mem_busy) begin
        if (mem_cnt == 0) begin
          imem_rvalid <= 1'b1;
          imem_rdata  <= mem_word(mem_paddr);
          mem_busy    <= 1'b0;
        end else begin
          mem_cnt <= mem_cnt - 1;
        end
      end else if (imem_gnt) begin
        if (rsp_lat <= 1) begin
          imem_rvalid <= 1'b1;
          imem_rdata  <= mem_word(imem_addr);
        end else begin
          mem_busy  <= 1'b1;
          mem_cnt   <= rsp_lat - 2;
          mem_paddr <= imem_addr;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic push_exp(input logic [8:0] a);
    sb_t e;
    e.addr = a;
    e.data = mem_word(a);
    sb_q.push_back(e);
  endtask

  // Pops the scoreboard on every decode handshake that is not squashed by a
  // branch, then advances one clock and settles.
  task automatic tick();
    sb_t e;
    if (!reset && instr_valid && instr_ready && !branch_taken) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_instr", 32'(instr_addr), 32'h1FF_FFFF);
      end else begin
        e = sb_q.pop_front();
        check("sb_addr", 32'(instr_addr), 32'(e.addr));
        check("sb_data", instr_data, e.data);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_to_next_req();
    tick();
    tick();
    check("hold_valid", 32'(instr_valid), 32'd1);
    tick();
  endtask

  initial begin
    br_tab[0] = '{target: 9'd508, exp_pc: 9'd508, exp_next: 9'd0};
    br_tab[1] = '{target: 9'h1FF, exp_pc: 9'h1FC, exp_next: 9'd0};
    br_tab[2] = '{target: 9'd3,   exp_pc: 9'd0,   exp_next: 9'd4};
    br_tab[3] = '{target: 9'd64,  exp_pc: 9'd64,  exp_next: 9'd68};
    br_tab[4] = '{target: 9'd101, exp_pc: 9'd100, exp_next: 9'd104};

    reset = 1'b1; branch_taken = 1'b0; branch_target = '0;
    instr_ready = 1'b0; gnt_en = 1'b1; rsp_lat = 1;
    repeat (3) tick();
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instr_data", instr_data, 32'd0);
    check("rst_instr_addr", 32'(instr_addr), 32'd0);

    // Sequential fetch: IDLE, then REQ/WAIT/HOLD per instruction.
    reset = 1'b0; instr_ready = 1'b1;
    for (int k = 0; k < 3; k++) push_exp(9'(4 * k));
    check("idle_req", 32'(imem_req), 32'd0);
    check("idle_valid", 32'(instr_valid), 32'd0);
    tick();
    for (int k = 0; k < 3; k++) begin
      check("seq_req", 32'(imem_req), 32'd1);
      check("seq_addr", 32'(imem_addr), 32'(4 * k));
      tick();
      check("seq_wait_valid", 32'(instr_valid), 32'd0);
      tick();
      check("seq_hold_valid", 32'(instr_valid), 32'd1);
      tick();
    end

    // Backpressure in HOLD.
    instr_ready = 1'b0;
    push_exp(9'd12);
    tick();
    tick();
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", 32'(instr_valid), 32'd1);
      check("bp_req", 32'(imem_req), 32'd0);
      check("bp_addr", 32'(instr_addr), 32'd12);
      check("bp_data", instr_data, mem_word(9'd12));
      tick();
    end
    instr_ready = 1'b1;
    tick();
    check("bp_next_addr", 32'(imem_addr), 32'd16);

    // Branch in HOLD with instr_ready high: squash, redirect, then sequential.
    for (int i = 0; i < 5; i++) begin
      tick();
      tick();
      branch_taken = 1'b1; branch_target = br_tab[i].target;
      tick();
      branch_taken = 1'b0;
      check("br_req", 32'(imem_req), 32'd1);
      check("br_addr", 32'(imem_addr), 32'(br_tab[i].exp_pc));
      check("br_valid", 32'(instr_valid), 32'd0);
      push_exp(br_tab[i].exp_pc);
      run_to_next_req();
      check("br_next_addr", 32'(imem_addr), 32'(br_tab[i].exp_next));
    end

    // Branch in REQ while the memory withholds grant.
    gnt_en = 1'b0;
    branch_taken = 1'b1; branch_target = 9'd200;
    tick();
    branch_taken = 1'b0;
    check("req_br_req", 32'(imem_req), 32'd1);
    check("req_br_addr", 32'(imem_addr), 32'd200);
    gnt_en = 1'b1;
    push_exp(9'd200);
    run_to_next_req();
    check("req_br_next", 32'(imem_addr), 32'd204);

    // Branch in WAIT coinciding with rvalid.
    tick();
    branch_taken = 1'b1; branch_target = 9'd40;
    tick();
    branch_taken = 1'b0;
    check("wrv_addr", 32'(imem_addr), 32'd40);
    check("wrv_req", 32'(imem_req), 32'd1);
    check("wrv_valid", 32'(instr_valid), 32'd0);
    push_exp(9'd40);
    run_to_next_req();

    // Branch in WAIT with slow memory: DRAIN until the stale response.
    rsp_lat = 3;
    tick();
    branch_taken = 1'b1; branch_target = 9'd100;
    tick();
    branch_taken = 1'b0;
    check("drain1_req", 32'(imem_req), 32'd0);
    check("drain1_valid", 32'(instr_valid), 32'd0);
    tick();
    check("drain2_req", 32'(imem_req), 32'd0);
    check("drain2_valid", 32'(instr_valid), 32'd0);
    tick();
    check("drain_exit_req", 32'(imem_req), 32'd1);
    check("drain_exit_addr", 32'(imem_addr), 32'd100);
    check("drain_exit_valid", 32'(instr_valid), 32'd0);
    rsp_lat = 1;
    push_exp(9'd100);
    run_to_next_req();

    // Reset while a slow request is outstanding.
    rsp_lat = 3;
    tick();
    reset = 1'b1;
    tick();
    check("wrst_req", 32'(imem_req), 32'd0);
    check("wrst_valid", 32'(instr_valid), 32'd0);
    check("wrst_addr", 32'(imem_addr), 32'd0);
    check("wrst_instr_addr", 32'(instr_addr), 32'd0);
    reset = 1'b0; rsp_lat = 1;
    push_exp(9'd0);
    tick();
    check("wrst_refetch_req", 32'(imem_req), 32'd1);
    check("wrst_refetch_addr", 32'(imem_addr), 32'd0);
    run_to_next_req();

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
